// File: rtl/led_fill_drain.sv
// LED bar sequencer: fills the bar one LED per step from the selected end,
// drains it in the same order, then repeats. A prescaler sets the step rate.
module led_fill_drain #(
  parameter int WIDTH = 8,
  parameter int DIV   = 25000000
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             en,
  input  logic             dir,
  input  logic             hold,
  output logic [WIDTH-1:0] led,
  output logic             phase,
  output logic             cycle_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]    CNT_MAX  = CW'(DIV - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             phase_q, phase_d;
  logic             cycle_done_q, cycle_done_d;
  logic             tick_s;
  logic [WIDTH-1:0] led_drain_s;

  function automatic logic [WIDTH-1:0] fill_step(input logic [WIDTH-1:0] v, input logic d);
    if (d) begin
      fill_step = {1'b1, v[WIDTH-1:1]};
    end else begin
      fill_step = {v[WIDTH-2:0], 1'b1};
    end
  endfunction

  // Draining shifts in the same direction as filling, so the first-lit LED goes out first.
  function automatic logic [WIDTH-1:0] drain_step(input logic [WIDTH-1:0] v, input logic d);
    if (d) begin
      drain_step = {1'b0, v[WIDTH-1:1]};
    end else begin
      drain_step = {v[WIDTH-2:0], 1'b0};
    end
  endfunction

  assign tick_s      = (cnt_q == CNT_MAX) & en & ~hold;
  assign led_drain_s = drain_step(led_q, dir_q);

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rs) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      led_q        <= '0;
      phase_q      <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      led_q        <= led_d;
      phase_q      <= phase_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  // Next state, prescaler and latched direction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
          cnt_d   = '0;
          dir_d   = dir;
        end
        ST_FILL, ST_DRAIN: begin
          if (hold) begin
            cnt_d = cnt_q;
          end else if (tick_s) begin
            cnt_d = '0;
            if ((state_q == ST_FILL) && (led_q == ALL_ONES)) begin
              state_d = ST_DRAIN;
            end else if ((state_q == ST_DRAIN) && (led_drain_s == ALL_ZERO)) begin
              state_d = ST_FILL;
              dir_d   = dir;
            end else begin
              state_d = state_q;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // LED pattern, phase and completion pulse for the next cycle.
  always_comb begin
    led_d        = led_q;
    cycle_done_d = 1'b0;
    phase_d      = (state_d == ST_FILL);
    if (!en) begin
      led_d = '0;
    end else if (!tick_s) begin
      led_d = (state_q == ST_IDLE) ? ALL_ZERO : led_q;
    end else begin
      case (state_q)
        ST_FILL: begin
          // A full bar starts draining on the same tick, with no dwell at full.
          if (led_q == ALL_ONES) begin
            led_d = led_drain_s;
          end else begin
            led_d = fill_step(led_q, dir_q);
          end
        end
        ST_DRAIN: begin
          led_d        = led_drain_s;
          cycle_done_d = (led_drain_s == ALL_ZERO);
        end
        default: begin
          led_d = '0;
        end
      endcase
    end
  end

  assign led        = led_q;
  assign phase      = phase_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_fill_drain.sv
// Scoreboard bench for led_fill_drain (WIDTH=8, DIV=4): a step-index reference
// model queues the expected outputs for every clock and they are popped after the edge.
module tb_led_fill_drain;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk  = 1'b0;
  logic         rs   = 1'b0;
  logic         en   = 1'b0;
  logic         dir  = 1'b0;
  logic         hold = 1'b0;
  logic [W-1:0] led;
  logic         phase;
  logic         cycle_done;

  led_fill_drain #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .rs(rs), .en(en), .dir(dir), .hold(hold),
    .led(led), .phase(phase), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] led;
    logic         ph;
    logic         cd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: state (0 idle, 1 fill, 2 drain), prescaler, step index 0..2W.
  int   m_state = 0;
  int   m_cnt   = 0;
  int   m_k     = 0;
  logic m_dir   = 1'b0;
  logic m_cd    = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Step k lights the first k LEDs while filling, then darkens the first k-W.
  function automatic logic [W-1:0] pat(input int k, input logic d);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) begin
      v[i] = (k <= W) ? (i < k) : (i >= k - W);
    end
    if (d) begin
      for (int i = 0; i < W; i++) pat[i] = v[W-1-i];
    end else begin
      pat = v;
    end
  endfunction

  task automatic model_step();
    m_cd = 1'b0;
    if (!rs) begin
      m_state = 0; m_cnt = 0; m_k = 0; m_dir = 1'b0;
    end else if (!en) begin
      m_state = 0; m_cnt = 0; m_k = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_cnt = 0; m_k = 0; m_dir = dir;
    end else if (hold) begin
      m_cnt = m_cnt;
    end else if (m_cnt == D - 1) begin
      m_cnt = 0;
      m_k++;
      if (m_state == 1 && m_k == W + 1) begin
        m_state = 2;
      end else if (m_state == 2 && m_k == 2 * W) begin
        m_state = 1; m_k = 0; m_cd = 1'b1; m_dir = dir;
      end
    end else begin
      m_cnt++;
    end
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e.led = pat(m_k, m_dir);
    e.ph  = (m_state == 1);
    e.cd  = m_cd;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("led", 32'(led), 32'(e.led));
    check_val("phase", 32'(phase), 32'(e.ph));
    check_val("cycle_done", 32'(cycle_done), 32'(e.cd));
  endtask

  int n;
  int cdn;

  initial begin
    // Reset with en high, then first-step latency.
    rs = 1'b0; en = 1'b1; dir = 1'b0; hold = 1'b0;
    step(); step();
    rs = 1'b1;
    n = 0;
    do begin step(); n++; end while (led == '0 && n < 20);
    check_val("first_step_latency", 32'(n), 32'd5);

    // Hold at led=07 with cnt=2.
    for (int i = 0; i < 100 && !(m_k == 3 && m_cnt == 2); i++) step();
    hold = 1'b1;
    repeat (10) step();
    hold = 1'b0;
    n = 0;
    do begin step(); n++; end while (led == 8'h07 && n < 20);
    check_val("hold_resume_latency", 32'(n), 32'd2);

    // Flip dir at led=0F; the current cycle must finish with the old pattern.
    for (int i = 0; i < 100 && !(m_k == 4); i++) step();
    dir = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (m_cd) break;
    end

    // One full dir=1 cycle; dir returns to 0 for the following cycle.
    cdn = 0;
    for (int i = 0; i < 2 * W * D; i++) begin
      step();
      if (cycle_done) cdn++;
      if (i == 20) dir = 1'b0;
    end
    check_val("cd_per_cycle", 32'(cdn), 32'd1);

    // en drop while draining at FC.
    for (int i = 0; i < 300 && !(m_state == 2 && m_k == W + 2); i++) step();
    en = 1'b0;
    step();
    en = 1'b1;

    // en drop on the final drain tick, with hold also raised: no step, no pulse.
    for (int i = 0; i < 300 && !(m_state == 2 && m_k == 2 * W - 1 && m_cnt == D - 1); i++) step();
    en = 1'b0; hold = 1'b1;
    step();
    en = 1'b1; hold = 1'b0;

    // Reset mid-fill, then restart.
    for (int i = 0; i < 300 && !(m_state == 1 && m_k == 3); i++) step();
    rs = 1'b0;
    step();
    rs = 1'b1;
    repeat (12) step();

    // Mixed random traffic.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 49) != 0);
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) dir = ~dir;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
